// File: rtl/markov_table_scheduler.sv
// markov_table_scheduler
//
// Schedules train, query and clear operations against an external synchronous
// transition-count table addressed by {prev, next}. Train does a read-modify-write
// increment that saturates at all-ones. Query reads a count back and presents it
// with a one-cycle strobe. Clear zeroes every entry, one address per cycle.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   trn_valid/trn_ready             train request handshake (ready is combinational)
//   trn_prev, trn_next              observed transition prev->next
//   qry_valid/qry_ready             query request handshake (ready is combinational)
//   qry_prev, qry_next              transition to look up
//   qry_rsp_valid, qry_rsp_count    response strobe and count (count holds until next response)
//   clr_start                       request zeroing of the whole table (honoured only when idle)
//   busy, done                      not idle; one-cycle pulse after the last clear write
//   trn_sat                         one-cycle pulse when a train write saturates
//   mem_addr/re/we/wdata/rdata      table port; rdata valid the cycle after mem_re
module markov_table_scheduler #(
    parameter int unsigned SYM_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trn_valid,
    output logic                 trn_ready,
    input  logic [SYM_W-1:0]     trn_prev,
    input  logic [SYM_W-1:0]     trn_next,
    input  logic                 qry_valid,
    output logic                 qry_ready,
    input  logic [SYM_W-1:0]     qry_prev,
    input  logic [SYM_W-1:0]     qry_next,
    output logic                 qry_rsp_valid,
    output logic [CNT_W-1:0]     qry_rsp_count,
    input  logic                 clr_start,
    output logic                 busy,
    output logic                 done,
    output logic                 trn_sat,
    output logic [2*SYM_W-1:0]   mem_addr,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic [CNT_W-1:0]     mem_wdata,
    input  logic [CNT_W-1:0]     mem_rdata
);

    localparam int unsigned AddrW = 2 * SYM_W;

    typedef enum logic [2:0] {
        StIdle,
        StTrnRd,
        StTrnWait,
        StTrnWr,
        StQryRd,
        StQryWait,
        StQryRsp,
        StClr
    } state_e;

    state_e             state_q, state_d;
    logic [SYM_W-1:0]   prev_q, prev_d;
    logic [SYM_W-1:0]   next_q, next_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rsp_count_q, rsp_count_d;
    logic [AddrW-1:0]   clr_addr_q, clr_addr_d;
    logic               favour_qry_q, favour_qry_d;
    logic               done_q, done_d;

    logic               grant_trn;
    logic               grant_qry;
    logic               cnt_full;

    // Round-robin: on contention the side not granted last wins.
    assign grant_trn = trn_valid & (~qry_valid | ~favour_qry_q);
    assign grant_qry = qry_valid & (~trn_valid | favour_qry_q);
    assign cnt_full  = &cnt_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            prev_q       <= '0;
            next_q       <= '0;
            cnt_q        <= '0;
            rsp_count_q  <= '0;
            clr_addr_q   <= '0;
            favour_qry_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            next_q       <= next_d;
            cnt_q        <= cnt_d;
            rsp_count_q  <= rsp_count_d;
            clr_addr_q   <= clr_addr_d;
            favour_qry_q <= favour_qry_d;
            done_q       <= done_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        next_d       = next_q;
        cnt_d        = cnt_q;
        rsp_count_d  = rsp_count_q;
        clr_addr_d   = clr_addr_q;
        favour_qry_d = favour_qry_q;
        done_d       = 1'b0;
        case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d    = StClr;
                    clr_addr_d = '0;
                end else if (grant_trn) begin
                    state_d      = StTrnRd;
                    prev_d       = trn_prev;
                    next_d       = trn_next;
                    favour_qry_d = 1'b1;
                end else if (grant_qry) begin
                    state_d      = StQryRd;
                    prev_d       = qry_prev;
                    next_d       = qry_next;
                    favour_qry_d = 1'b0;
                end
            end
            StTrnRd:   state_d = StTrnWait;
            StTrnWait: begin
                cnt_d   = mem_rdata;
                state_d = StTrnWr;
            end
            StTrnWr:   state_d = StIdle;
            StQryRd:   state_d = StQryWait;
            StQryWait: begin
                rsp_count_d = mem_rdata;
                state_d     = StQryRsp;
            end
            StQryRsp:  state_d = StIdle;
            StClr: begin
                if (&clr_addr_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + AddrW'(1);
                end
            end
            default:   state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        trn_ready     = 1'b0;
        qry_ready     = 1'b0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        trn_sat       = 1'b0;
        qry_rsp_valid = 1'b0;
        case (state_q)
            StIdle: begin
                trn_ready = ~clr_start & grant_trn;
                qry_ready = ~clr_start & grant_qry;
            end
            StTrnRd, StQryRd: begin
                mem_re   = 1'b1;
                mem_addr = {prev_q, next_q};
            end
            StTrnWr: begin
                mem_we    = 1'b1;
                mem_addr  = {prev_q, next_q};
                mem_wdata = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
                trn_sat   = cnt_full;
            end
            StQryRsp:  qry_rsp_valid = 1'b1;
            StClr: begin
                mem_we   = 1'b1;
                mem_addr = clr_addr_q;
            end
            default: ;
        endcase
        // A reset cycle must not start or complete any table access or handshake.
        if (reset) begin
            trn_ready = 1'b0;
            qry_ready = 1'b0;
            mem_re    = 1'b0;
            mem_we    = 1'b0;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign qry_rsp_count = rsp_count_q;

endmodule

// File: tb/tb_markov_table_scheduler.sv
// Bench for markov_table_scheduler: table vectors, hand-written corner sequences and a
// randomized run checked against a count-array model of the transition table.
module tb_markov_table_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       trn_valid, trn_ready;
    logic [3:0] trn_prev, trn_next;
    logic       qry_valid, qry_ready;
    logic [3:0] qry_prev, qry_next;
    logic       qry_rsp_valid;
    logic [7:0] qry_rsp_count;
    logic       clr_start, busy, done, trn_sat;
    logic [7:0] mem_addr;
    logic       mem_re, mem_we;
    logic [7:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    markov_table_scheduler #(.SYM_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .trn_valid(trn_valid), .trn_ready(trn_ready), .trn_prev(trn_prev), .trn_next(trn_next),
        .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_prev(qry_prev), .qry_next(qry_next),
        .qry_rsp_valid(qry_rsp_valid), .qry_rsp_count(qry_rsp_count),
        .clr_start(clr_start), .busy(busy), .done(done), .trn_sat(trn_sat),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Table memory with one-cycle read latency; poke lets the bench preload entries.
    logic [7:0] mem [256];
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr, poke_data;
    int         illegal_cnt = 0;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (poke_en) mem[poke_addr] <= poke_data;
        if (mem_re && mem_we) illegal_cnt <= illegal_cnt + 1;
    end

    int model [256];

    typedef struct packed {
        logic       is_qry;
        logic [3:0] p;
        logic [3:0] n;
        logic [7:0] exp;
        logic       exp_sat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        step();
        poke_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; trn_valid = 1'b0; qry_valid = 1'b0; clr_start = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic handshake(input bit is_qry, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = is_qry ? qry_ready : trn_ready;
            step();
        end
        check(is_qry ? "qry_handshake" : "trn_handshake", ok, 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
            step();
        end
        check("wait_idle", idle, 1);
    endtask

    task automatic do_train(input logic [3:0] p, input logic [3:0] n, output int re_k,
                            output int we_k, output int idle_k, output int sat_n,
                            output logic [7:0] wdata, output logic [7:0] waddr);
        bit ok;
        re_k = -1; we_k = -1; idle_k = -1; sat_n = 0; wdata = 8'h0; waddr = 8'h0;
        trn_valid = 1'b1; trn_prev = p; trn_next = n;
        handshake(1'b0, ok);
        trn_valid = 1'b0;
        for (int k = 1; k <= 10 && ok && idle_k < 0; k++) begin
            @(negedge clk);
            if (mem_re && re_k < 0) re_k = k;
            if (mem_we) begin we_k = k; wdata = mem_wdata; waddr = mem_addr; end
            if (trn_sat) sat_n++;
            if (!busy) idle_k = k;
            step();
        end
    endtask

    task automatic do_query(input logic [3:0] p, input logic [3:0] n, output int rsp_k,
                            output int rsp_n, output int idle_k, output logic [7:0] cnt);
        bit ok;
        rsp_k = -1; rsp_n = 0; idle_k = -1; cnt = 8'h0;
        qry_valid = 1'b1; qry_prev = p; qry_next = n;
        handshake(1'b1, ok);
        qry_valid = 1'b0;
        for (int k = 1; k <= 10 && ok && idle_k < 0; k++) begin
            @(negedge clk);
            if (qry_rsp_valid) begin rsp_n++; rsp_k = k; cnt = qry_rsp_count; end
            if (!busy) idle_k = k;
            step();
        end
    endtask

    task automatic do_clear();
        int writes = 0, bad = 0, dones = 0, last_wr = -1, done_k = -1;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (mem_re) bad++;
            if (mem_we) begin
                if (mem_addr != 8'(writes) || mem_wdata != 8'h0 || last_wr != k - 1) bad++;
                writes++;
                last_wr = k;
            end
            if (done) begin dones++; done_k = k; end
        end
        check("clr_write_count", writes, 256);
        check("clr_write_errors", bad, 0);
        check("clr_done_once", dones, 1);
        check("clr_done_timing", done_k, last_wr + 1);
        check("clr_busy_after", busy, 0);
        step();
    endtask

    task automatic preload();
        poke(8'h00, 8'd253);
        poke(8'h11, 8'd255);
        model[8'h00] = 253;
        model[8'h11] = 255;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int re_k, we_k, idle_k, sat_n, rsp_k, rsp_n, r, nz, exp, last_rsp, ng, both, wrs, dns;
        int g_k [4];
        bit g_q [4];
        bit ok;
        logic [7:0] wdata, waddr, cnt, a;
        logic [3:0] p, n;

        trn_prev = 4'h0; trn_next = 4'h0; qry_prev = 4'h0; qry_next = 4'h0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_readys", {trn_ready, qry_ready}, 0);
        check("rst_strobes", {qry_rsp_valid, done, trn_sat, mem_re, mem_we}, 0);
        check("rst_rsp_count", qry_rsp_count, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        step();

        // Clear priority over pending requests, then a full clear over garbage
        poke(8'h00, 8'h5a);
        poke(8'h80, 8'h11);
        poke(8'hff, 8'hff);
        trn_valid = 1'b1; qry_valid = 1'b1; clr_start = 1'b1;
        #1;
        check("clr_priority_readys", {trn_ready, qry_ready}, 0);
        trn_valid = 1'b0; qry_valid = 1'b0; clr_start = 1'b0;
        #1;
        do_clear();
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != 8'h0) nz++;
        check("clr_table_zero", nz, 0);

        // Table-driven train/query vectors on a cleared table
        vecs[0]  = '{1'b0, 4'h3, 4'h5, 8'd1, 1'b0};
        vecs[1]  = '{1'b0, 4'h3, 4'h5, 8'd2, 1'b0};
        vecs[2]  = '{1'b0, 4'h3, 4'h5, 8'd3, 1'b0};
        vecs[3]  = '{1'b1, 4'h3, 4'h5, 8'd3, 1'b0};
        vecs[4]  = '{1'b1, 4'h5, 4'h3, 8'd0, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 4'h0, 8'd1, 1'b0};
        vecs[6]  = '{1'b1, 4'h0, 4'h0, 8'd1, 1'b0};
        vecs[7]  = '{1'b0, 4'hf, 4'hf, 8'd1, 1'b0};
        vecs[8]  = '{1'b0, 4'hf, 4'h0, 8'd1, 1'b0};
        vecs[9]  = '{1'b1, 4'hf, 4'hf, 8'd1, 1'b0};
        vecs[10] = '{1'b1, 4'hf, 4'h0, 8'd1, 1'b0};
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].is_qry) begin
                do_query(vecs[v].p, vecs[v].n, rsp_k, rsp_n, idle_k, cnt);
                check($sformatf("vec%0d_qry_count", v), cnt, vecs[v].exp);
                check($sformatf("vec%0d_qry_latency", v), rsp_k, 3);
                check($sformatf("vec%0d_qry_pulses", v), rsp_n, 1);
                check($sformatf("vec%0d_qry_idle", v), idle_k, 4);
            end else begin
                do_train(vecs[v].p, vecs[v].n, re_k, we_k, idle_k, sat_n, wdata, waddr);
                check($sformatf("vec%0d_trn_wdata", v), wdata, vecs[v].exp);
                check($sformatf("vec%0d_trn_addr", v), waddr, {vecs[v].p, vecs[v].n});
                check($sformatf("vec%0d_trn_sat", v), sat_n, vecs[v].exp_sat);
                check($sformatf("vec%0d_trn_timing", v), {re_k[7:0], we_k[7:0], idle_k[7:0]},
                      {8'd1, 8'd3, 8'd4});
            end
        end

        // Saturation
        poke(8'h35, 8'd255);
        do_train(4'h3, 4'h5, re_k, we_k, idle_k, sat_n, wdata, waddr);
        check("sat_wdata", wdata, 255);
        check("sat_pulse", sat_n, 1);
        do_query(4'h3, 4'h5, rsp_k, rsp_n, idle_k, cnt);
        check("sat_query", cnt, 255);
        // Response count holds across a following train
        do_train(4'h0, 4'h1, re_k, we_k, idle_k, sat_n, wdata, waddr);
        check("rsp_count_hold", qry_rsp_count, 255);

        // clr_start during TRN_WAIT is dropped
        poke(8'h77, 8'd10);
        trn_valid = 1'b1; trn_prev = 4'h7; trn_next = 4'h7;
        handshake(1'b0, ok);
        trn_valid = 1'b0;
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        wrs = 0; dns = 0;
        for (int k = 0; k < 280; k++) begin
            @(negedge clk);
            if (mem_we) wrs++;
            if (done) dns++;
        end
        step();
        check("clr_ignored_writes", wrs, 1);
        check("clr_ignored_done", dns, 0);
        check("clr_ignored_value", mem[8'h77], 11);
        check("clr_ignored_busy", busy, 0);

        // Reset during TRN_WAIT
        poke(8'h42, 8'd5);
        do_query(4'h4, 4'h2, rsp_k, rsp_n, idle_k, cnt);
        check("pre_reset_query", cnt, 5);
        trn_valid = 1'b1; trn_prev = 4'h4; trn_next = 4'h2;
        handshake(1'b0, ok);
        trn_valid = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        check("reset_cycle_no_we", mem_we, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_strobes", {qry_rsp_valid, done, trn_sat, mem_re, mem_we}, 0);
        check("post_reset_rsp_count", qry_rsp_count, 0);
        check("post_reset_bus", {mem_addr, mem_wdata}, 0);
        wrs = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_we || mem_re) wrs++;
        end
        step();
        check("post_reset_no_access", wrs, 0);
        check("post_reset_mem", mem[8'h42], 5);

        // Round-robin with both requesters held from reset
        do_reset();
        trn_valid = 1'b1; qry_valid = 1'b1;
        trn_prev = 4'h1; trn_next = 4'h2; qry_prev = 4'h1; qry_next = 4'h2;
        ng = 0; both = 0;
        for (int i = 0; i < 4; i++) begin g_k[i] = -100; g_q[i] = 1'b0; end
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clk);
            if (trn_ready && qry_ready) both++;
            if (trn_ready || qry_ready) begin g_k[ng] = k; g_q[ng] = qry_ready; ng++; end
            step();
        end
        trn_valid = 1'b0; qry_valid = 1'b0;
        wait_idle();
        check("rr_grants", ng, 4);
        check("rr_both_ready", both, 0);
        check("rr_order", {g_q[0], g_q[1], g_q[2], g_q[3]}, 4'b0101);
        check("rr_spacing", {g_k[1] - g_k[0], g_k[2] - g_k[1], g_k[3] - g_k[2]}, {32'd4, 32'd4, 32'd4});

        // Randomized run against the count model
        do_clear();
        for (int i = 0; i < 256; i++) model[i] = 0;
        preload();
        do_query(4'h0, 4'h0, rsp_k, rsp_n, idle_k, cnt);
        check("rnd_first_query", cnt, model[8'h00]);
        last_rsp = model[8'h00];
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                p = 4'($urandom_range(0, 1));
                n = 4'($urandom_range(0, 1));
            end else begin
                p = 4'($urandom);
                n = 4'($urandom);
            end
            a = {p, n};
            r = $urandom_range(0, 99);
            if (r == 0) begin
                do_clear();
                for (int i = 0; i < 256; i++) model[i] = 0;
                preload();
            end else if (r < 55) begin
                do_train(p, n, re_k, we_k, idle_k, sat_n, wdata, waddr);
                exp = (model[a] + 1 > 255) ? 255 : model[a] + 1;
                check("rnd_trn_wdata", wdata, exp);
                check("rnd_trn_addr", waddr, a);
                check("rnd_trn_sat", sat_n, (model[a] == 255) ? 1 : 0);
                check("rnd_trn_latency", we_k, 3);
                check("rnd_rsp_hold", qry_rsp_count, last_rsp);
                model[a] = exp;
            end else begin
                do_query(p, n, rsp_k, rsp_n, idle_k, cnt);
                check("rnd_qry_count", cnt, model[a]);
                check("rnd_qry_latency", rsp_k, 3);
                check("rnd_qry_pulses", rsp_n, 1);
                last_rsp = model[a];
            end
        end

        check("mem_re_we_exclusive", illegal_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
